// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction sequencer and the datapath it drives.
// Optional stall input is present only when CPU_CTRL_STALL_EN is defined.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
`ifdef CPU_CTRL_STALL_EN
    logic       stall;
`endif
    logic [2:0] phase;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       halt;
    logic       inc_pc;
    logic       ld_ac;
    logic       ld_pc;
    logic       wr;
    logic       data_e;

`ifdef CPU_CTRL_STALL_EN
    modport master (
        output opcode, zero, stall,
        input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );
    modport slave (
        input  opcode, zero, stall,
        output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );
`else
    modport master (
        output opcode, zero,
        input  phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );
    modport slave (
        input  opcode, zero,
        output phase, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e
    );
`endif
endinterface

// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer for the accumulator CPU; strobes are a zero-latency decode of the phase.
// Define CPU_CTRL_STALL_EN to add a stall input that freezes the sequencer and masks all strobes but halt.
module cpu_controller (
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.slave  bus
);
    localparam int NUM_PHASES = 8;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam phase_t LAST_PHASE = phase_t'(3'(NUM_PHASES - 1));

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;
    logic   w_stall;
    logic   w_aluop;
    logic   w_sel, w_rd, w_ld_ir, w_halt, w_inc_pc, w_ld_ac, w_ld_pc, w_wr, w_data_e;

`ifdef CPU_CTRL_STALL_EN
    assign w_stall = bus.stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                     (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        w_sel        = 1'b0;
        w_rd         = 1'b0;
        w_ld_ir      = 1'b0;
        w_halt       = 1'b0;
        w_inc_pc     = 1'b0;
        w_ld_ac      = 1'b0;
        w_ld_pc      = 1'b0;
        w_wr         = 1'b0;
        w_data_e     = 1'b0;

        // A HLT seen in OP_ADDR latches halted and leaves the phase parked at OP_ADDR.
        if (!r_halted && !w_stall) begin
            if (r_phase == OP_ADDR && bus.opcode == OP_HLT)
                w_halted_nxt = 1'b1;
            else if (r_phase == LAST_PHASE)
                w_phase_nxt = INST_ADDR;
            else
                w_phase_nxt = phase_t'(r_phase + 3'd1);
        end

        if (r_halted) begin
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                INST_ADDR: w_sel = 1'b1;
                INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    w_inc_pc = 1'b1;
                    w_halt   = (bus.opcode == OP_HLT);
                end
                OP_FETCH: w_rd = w_aluop;
                ALU_OP: begin
                    w_rd     = w_aluop;
                    w_inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    w_ld_pc  = (bus.opcode == OP_JMP);
                    w_data_e = (bus.opcode == OP_STO);
                end
                STORE: begin
                    w_rd     = w_aluop;
                    w_ld_ac  = w_aluop;
                    w_ld_pc  = (bus.opcode == OP_JMP);
                    w_wr     = (bus.opcode == OP_STO);
                    w_data_e = (bus.opcode == OP_STO);
                end
                default: w_sel = 1'b0;
            endcase

            if (w_stall) begin
                w_sel    = 1'b0;
                w_rd     = 1'b0;
                w_ld_ir  = 1'b0;
                w_inc_pc = 1'b0;
                w_ld_ac  = 1'b0;
                w_ld_pc  = 1'b0;
                w_wr     = 1'b0;
                w_data_e = 1'b0;
            end
        end
    end

    assign bus.phase  = r_phase;
    assign bus.sel    = w_sel;
    assign bus.rd     = w_rd;
    assign bus.ld_ir  = w_ld_ir;
    assign bus.halt   = w_halt;
    assign bus.inc_pc = w_inc_pc;
    assign bus.ld_ac  = w_ld_ac;
    assign bus.ld_pc  = w_ld_pc;
    assign bus.wr     = w_wr;
    assign bus.data_e = w_data_e;
endmodule
